stack_ctrl: RTL
===============

# stack_ctrl

Controller for the return-address stack memory (16 × 10-bit) of the processor. It owns the stack pointer and shares the stack between two requesters: the core (jal push / ret pop) and the interrupt unit (entry push / reti pop). Requests are arbitrated with fixed priority, sequenced through a small FSM with a req/ack handshake, and checked for overflow and underflow. It drives the stack memory's write enable, address and write data directly, replacing the free-running adder and pointer register arrangement.

## Interface
- DW, 10, data/address width stored per entry
- DEPTH, 16, number of stack entries
- AW, 4, memory address width, equal to log2(DEPTH)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- core_push  in  1  core requests push of core_wdata; held until core_ack
- core_pop  in  1  core requests pop; held until core_ack
- core_wdata  in  DW  return address to push
- core_ack  out  1  one-cycle pulse, core operation complete
- irq_push  in  1  interrupt unit requests push of irq_wdata; held until irq_ack
- irq_pop  in  1  interrupt unit requests pop; held until irq_ack
- irq_wdata  in  DW  interrupted PC to push
- irq_ack  out  1  one-cycle pulse, interrupt operation complete
- rdata  out  DW  popped value, valid in the cycle of the pop ack, held until the next pop
- mem_we  out  1  stack memory write enable
- mem_addr  out  AW  stack memory address
- mem_wdata  out  DW  stack memory write data
- mem_rdata  in  DW  stack memory read data, combinational from mem_addr
- count  out  AW+1  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- ovf  out  1  push attempted while full
- udf  out  1  pop attempted while empty

## Operation
- FSM states: IDLE, PUSH, POP, ERR (ERR exists only with the trap macro).
- IDLE: sample requests. Grant order is irq over core. Within one requester, push wins over simultaneous pop, which is illegal. Latch the grant, op and wdata, then go to PUSH or POP. No request keeps the FSM in IDLE.
- PUSH, not full: mem_we=1, mem_addr=count[AW-1:0], mem_wdata=latched data, count+1, ack to the granted requester, return to IDLE.
- POP, not empty: mem_addr=count-1, rdata<=mem_rdata, count-1, ack, return to IDLE.
- Push while full: no write, count unchanged, ack still issued, ovf handled per Configuration.
- Pop while empty: rdata<=0, count unchanged, ack still issued, udf handled per Configuration.
- mem_we is asserted only in PUSH and never when full. mem_addr is 0 in IDLE.
- The losing requester keeps its request held and is served on the next IDLE visit. There is no fairness guarantee beyond the fixed priority.

## Timing
- Reset values: state IDLE, count=0, empty=1, full=0, rdata=0, every ack, mem_we, ovf and udf at 0, mem_addr=0, mem_wdata=0.
- Request seen in IDLE at edge N; op executes and ack pulses in cycle N+1; IDLE again at N+2.
- Throughput is one operation per 2 cycles.
- Requests must be deasserted or changed in the cycle after ack; a still-held request starts a new op.
- Reset asserted mid-operation aborts the op: no ack, no write, count=0.
- full, empty and count are registered and update at the edge that completes the op.

## Configuration
- STACK_CTRL_TRAP_EN defined:
  - ovf and udf are sticky.
  - The FSM enters ERR after the acked faulting op.
  - ERR grants nothing and leaves acks low until reset.
- STACK_CTRL_TRAP_EN undefined:
  - ovf and udf pulse for exactly the cycle of the faulting ack.
  - The FSM returns to IDLE and operation continues.

## Structure
- Package stack_ctrl_pkg holds:
  - the state enum (IDLE, PUSH, POP, ERR)
  - the requester-id encoding (REQ_CORE, REQ_IRQ)
  - DW/DEPTH defaults
- Sub-module stack_arb: fixed-priority two-requester arbiter producing grant id and op (push/pop). It is combinational, and its output is registered in stack_ctrl.

## Test plan
- Core pushes 10'h12A, then 10'h3F0, then pops twice -> acks at N+1, rdata 10'h3F0 then 10'h12A, count 2→0, empty=1.
- irq_push 10'h055 and core_push 10'h111 asserted together -> irq served first (mem_addr 0 = 10'h055), core next (mem_addr 1 = 10'h111).
- 17 pushes -> full=1 after the 16th. The 17th is acked with no mem_we and ovf=1 (sticky and ERR with the macro; one-cycle pulse without).
- Pop on empty -> ack, rdata=0, udf=1, count stays 0.
- reset low in the cycle after a push request -> no mem_we, no ack, count=0, all outputs at reset values.
- Fill to 16 and pop all -> LIFO order preserved across the full depth, then empty=1.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared types for the return-address stack controller: FSM states, requester ids, size defaults.
package stack_ctrl_pkg;

    localparam int DW_DEF    = 10;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_IRQ  = 1'b1
    } req_id_t;

endpackage

// File: rtl/stack_arb.sv
// Fixed-priority arbiter between core and interrupt stack requests; irq beats core, push beats pop.
// Latency: combinational, the caller registers the result.
// Backpressure: none here; a losing request is simply not granted and must stay held.
module stack_arb
    import stack_ctrl_pkg::*;
(
    input  logic    core_push,
    input  logic    core_pop,
    input  logic    irq_push,
    input  logic    irq_pop,
    output logic    grant_vld,
    output req_id_t grant_id,
    output logic    grant_push
);

    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = REQ_CORE;
        grant_push = 1'b0;
        if (irq_push || irq_pop) begin
            grant_vld  = 1'b1;
            grant_id   = REQ_IRQ;
            grant_push = irq_push;
        end else if (core_push || core_pop) begin
            grant_vld  = 1'b1;
            grant_id   = REQ_CORE;
            grant_push = core_push;
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Return-address stack controller: owns the pointer, arbitrates core/irq push and pop, flags ovf/udf.
// Latency: request sampled in IDLE at edge N, op and ack in cycle N+1, IDLE again at N+2.
// Backpressure: requests are held until ack; STACK_CTRL_TRAP_EN makes ovf/udf sticky and parks in ERR.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_push,
    input  logic          core_pop,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    input  logic          irq_push,
    input  logic          irq_pop,
    input  logic [DW-1:0] irq_wdata,
    output logic          irq_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state;
    logic [DW-1:0] rdata_q;
    logic          grant_vld;
    req_id_t       grant_id;
    logic          grant_push;
    logic [DW-1:0] wdata_sel;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count_inc;
    logic [AW:0]   count_dec;

    stack_arb u_arb (
        .core_push  (core_push),
        .core_pop   (core_pop),
        .irq_push   (irq_push),
        .irq_pop    (irq_pop),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id),
        .grant_push (grant_push)
    );

    assign wdata_sel = (grant_id == REQ_IRQ) ? irq_wdata : core_wdata;
    assign count_inc = count + 1'b1;
    assign count_dec = count - 1'b1;

    // Popped value is visible during the ack cycle and held afterwards; empty pops return zero.
    assign pop_data = empty ? '0 : mem_rdata;
    assign rdata    = (state == POP) ? pop_data : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rdata_q   <= '0;
            core_ack  <= 1'b0;
            irq_ack   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state    <= grant_push ? PUSH : POP;
                        core_ack <= (grant_id == REQ_CORE);
                        irq_ack  <= (grant_id == REQ_IRQ);
                        if (grant_push) begin
                            mem_we    <= !full;
                            mem_addr  <= count[AW-1:0];
                            mem_wdata <= wdata_sel;
`ifdef STACK_CTRL_TRAP_EN
                            ovf       <= ovf | full;
`else
                            ovf       <= full;
`endif
                        end else begin
                            mem_addr <= empty ? '0 : count_dec[AW-1:0];
`ifdef STACK_CTRL_TRAP_EN
                            udf      <= udf | empty;
`else
                            udf      <= empty;
`endif
                        end
                    end
                end
                PUSH: begin
                    if (!full) begin
                        count <= count_inc;
                        full  <= (count_inc == DEPTH_C);
                        empty <= 1'b0;
                    end
                    core_ack <= 1'b0;
                    irq_ack  <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
`ifdef STACK_CTRL_TRAP_EN
                    // ovf was just set by this op if it faulted; anything earlier would have parked us in ERR.
                    state    <= ovf ? ERR : IDLE;
`else
                    ovf      <= 1'b0;
                    state    <= IDLE;
`endif
                end
                POP: begin
                    rdata_q <= pop_data;
                    if (!empty) begin
                        count <= count_dec;
                        empty <= (count_dec == '0);
                        full  <= 1'b0;
                    end
                    core_ack <= 1'b0;
                    irq_ack  <= 1'b0;
                    mem_addr <= '0;
`ifdef STACK_CTRL_TRAP_EN
                    state    <= udf ? ERR : IDLE;
`else
                    udf      <= 1'b0;
                    state    <= IDLE;
`endif
                end
                default: begin
`ifdef STACK_CTRL_TRAP_EN
                    state <= ERR;
`else
                    state <= IDLE;
`endif
                    core_ack <= 1'b0;
                    irq_ack  <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule
